// File: rtl/ddr4_v2_2_20_mc_cmd_arb_mux_n.sv
// Registered N-source command arbiter/multiplexer for the MC command path.
// Picks one requesting source per cycle (round-robin or fixed priority),
// pops it through a one-hot grant and holds the chosen command in a
// one-deep output register that drains through a valid/ready handshake.
//
// Handshake: winVld marks a held command; it is consumed on a clock edge
// where winVld && winRdy. The register can load whenever it is empty or
// being consumed (ld = ~winVld | winRdy); a source is popped on the same
// edge its cmdGnt bit is high, so cmdGnt is only ever raised while ld=1.
module ddr4_v2_2_20_mc_cmd_arb_mux_n #(
    parameter int NUM_CH   = 4,
    parameter int CHW      = 2,
    parameter int COLBITS  = 10,
    parameter int RKBITS   = 2,
    parameter int LR_WIDTH = 1,
    parameter int DBAW     = 5,
    parameter int RR_EN    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            cmdReq,
    input  logic [2*NUM_CH-1:0]          cmdBank,
    input  logic [2*NUM_CH-1:0]          cmdGroup,
    input  logic [DBAW*NUM_CH-1:0]       cmdBuf,
    input  logic [COLBITS*NUM_CH-1:0]    cmdCol,
    input  logic [RKBITS*NUM_CH-1:0]     cmdRank,
    input  logic [LR_WIDTH*NUM_CH-1:0]   cmdLRank,
    input  logic [NUM_CH-1:0]            cmdInjTxn,
    input  logic [NUM_CH-1:0]            cmdRmw,
    input  logic [NUM_CH-1:0]            cmdAP,
    input  logic [NUM_CH-1:0]            cmdSize,
    input  logic                         winRdy,
    output logic [NUM_CH-1:0]            cmdGnt,
    output logic                         winVld,
    output logic [CHW-1:0]               winSel,
    output logic [1:0]                   winBank,
    output logic [1:0]                   winGroup,
    output logic [DBAW-1:0]              winBuf,
    output logic [COLBITS-1:0]           winCol,
    output logic [RKBITS-1:0]            winRank,
    output logic [LR_WIDTH-1:0]          winLRank,
    output logic                         winInjTxn,
    output logic                         winRmw,
    output logic                         winAP,
    output logic                         winSize
);

    logic                 ld;
    logic [CHW-1:0]       rr_ptr;
    logic                 found;
    int                   win_idx;
    int                   best_off;
    int                   arb_off;
    int                   base;

    logic [1:0]           sel_bank;
    logic [1:0]           sel_group;
    logic [DBAW-1:0]      sel_buf;
    logic [COLBITS-1:0]   sel_col;
    logic [RKBITS-1:0]    sel_rank;
    logic [LR_WIDTH-1:0]  sel_lrank;
    logic                 sel_inj;
    logic                 sel_rmw;
    logic                 sel_ap;
    logic                 sel_size;
    logic [COLBITS-1:0]   fmt_col;
    logic                 unused_col;

    assign ld = ~winVld | winRdy;

    // Winner = requester with the smallest rotated distance from the search base.
    always_comb begin
        base     = (RR_EN != 0) ? int'(rr_ptr) : 0;
        best_off = NUM_CH;
        arb_off  = 0;
        win_idx  = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            arb_off = (j >= base) ? (j - base) : (j + NUM_CH - base);
            if (cmdReq[j] && (arb_off < best_off)) begin
                best_off = arb_off;
                win_idx  = j;
            end
        end
        found = (best_off < NUM_CH);
    end

    // One-hot grant; only while the output register can take the command.
    always_comb begin
        cmdGnt = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!rst && ld && found && (j == win_idx)) cmdGnt[j] = 1'b1;
        end
    end

    // Field mux for the current winner.
    always_comb begin
        sel_bank  = '0;
        sel_group = '0;
        sel_buf   = '0;
        sel_col   = '0;
        sel_rank  = '0;
        sel_lrank = '0;
        sel_inj   = 1'b0;
        sel_rmw   = 1'b0;
        sel_ap    = 1'b0;
        sel_size  = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (j == win_idx) begin
                sel_bank  = cmdBank[j*2 +: 2];
                sel_group = cmdGroup[j*2 +: 2];
                sel_buf   = cmdBuf[j*DBAW +: DBAW];
                sel_col   = cmdCol[j*COLBITS +: COLBITS];
                sel_rank  = cmdRank[j*RKBITS +: RKBITS];
                sel_lrank = cmdLRank[j*LR_WIDTH +: LR_WIDTH];
                sel_inj   = cmdInjTxn[j];
                sel_rmw   = cmdRmw[j];
                sel_ap    = cmdAP[j];
                sel_size  = cmdSize[j];
            end
        end
    end

    // Column as issued: bit 2 only survives for BL8, bit 1 is always zero and
    // bit 0 carries the injected-transaction flag; the source's low bits drop.
    assign fmt_col    = {sel_col[COLBITS-1:3], sel_size ? sel_col[2] : 1'b0, 1'b0, sel_inj};
    assign unused_col = ^sel_col[1:0];

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winVld    <= 1'b0;
            winSel    <= '0;
            winBank   <= '0;
            winGroup  <= '0;
            winBuf    <= '0;
            winCol    <= '0;
            winRank   <= '0;
            winLRank  <= '0;
            winInjTxn <= 1'b0;
            winRmw    <= 1'b0;
            winAP     <= 1'b0;
            winSize   <= 1'b0;
            rr_ptr    <= '0;
        end else if (ld) begin
            if (found) begin
                winVld    <= 1'b1;
                winSel    <= CHW'(win_idx);
                winBank   <= sel_bank;
                winGroup  <= sel_group;
                winBuf    <= sel_buf;
                winCol    <= fmt_col;
                winRank   <= sel_rank;
                winLRank  <= sel_lrank;
                winInjTxn <= sel_inj;
                winRmw    <= sel_rmw;
                winAP     <= sel_ap & ~sel_rmw;
                winSize   <= sel_size;
                if (RR_EN != 0) begin
                    rr_ptr <= (win_idx == NUM_CH - 1) ? '0 : CHW'(win_idx + 1);
                end
            end else begin
                winVld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_cmd_arb_mux_n.sv
// Bench for the command arbiter/mux: three instances (4-source round-robin,
// 4-source fixed priority, 8-source round-robin) share the source field
// buses; each has its own request/ready inputs and its own expected queue.
module tb_ddr4_v2_2_20_mc_cmd_arb_mux_n;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- source model ----------------
    logic [1:0] s_bank[8];
    logic [1:0] s_group[8];
    logic [4:0] s_buf[8];
    logic [9:0] s_col[8];
    logic [1:0] s_rank[8];
    logic       s_lrank[8];
    logic       s_inj[8];
    logic       s_rmw[8];
    logic       s_ap[8];
    logic       s_size[8];

    logic [15:0] bank8, group8, rank8;
    logic [39:0] buf8;
    logic [79:0] col8;
    logic [7:0]  lrank8, inj8, rmw8, ap8, size8;

    always_comb begin
        bank8 = '0; group8 = '0; rank8 = '0; buf8 = '0; col8 = '0;
        lrank8 = '0; inj8 = '0; rmw8 = '0; ap8 = '0; size8 = '0;
        for (int k = 0; k < 8; k++) begin
            bank8[k*2 +: 2]   = s_bank[k];
            group8[k*2 +: 2]  = s_group[k];
            rank8[k*2 +: 2]   = s_rank[k];
            buf8[k*5 +: 5]    = s_buf[k];
            col8[k*10 +: 10]  = s_col[k];
            lrank8[k]         = s_lrank[k];
            inj8[k]           = s_inj[k];
            rmw8[k]           = s_rmw[k];
            ap8[k]            = s_ap[k];
            size8[k]          = s_size[k];
        end
    end

    // ---------------- DUT instances ----------------
    logic [3:0] req4, reqfp, gnt4, gntfp;
    logic       rdy4, rdyfp;
    logic [7:0] req8, gnt8;
    logic       rdy8;

    logic       vld4, vldfp, vld8;
    logic [1:0] sel4, selfp;
    logic [2:0] sel8;
    logic [1:0] o4_bank, o4_group, o4_rank, ofp_bank, ofp_group, ofp_rank, o8_bank, o8_group, o8_rank;
    logic [4:0] o4_buf, ofp_buf, o8_buf;
    logic [9:0] o4_col, ofp_col, o8_col;
    logic [0:0] o4_lrank, ofp_lrank, o8_lrank;
    logic       o4_inj, o4_rmw, o4_ap, o4_size;
    logic       ofp_inj, ofp_rmw, ofp_ap, ofp_size;
    logic       o8_inj, o8_rmw, o8_ap, o8_size;

    ddr4_v2_2_20_mc_cmd_arb_mux_n #(.NUM_CH(4), .CHW(2), .RR_EN(1)) u_rr4 (
        .clk(clk), .rst(rst), .cmdReq(req4),
        .cmdBank(bank8[7:0]), .cmdGroup(group8[7:0]), .cmdBuf(buf8[19:0]),
        .cmdCol(col8[39:0]), .cmdRank(rank8[7:0]), .cmdLRank(lrank8[3:0]),
        .cmdInjTxn(inj8[3:0]), .cmdRmw(rmw8[3:0]), .cmdAP(ap8[3:0]), .cmdSize(size8[3:0]),
        .winRdy(rdy4), .cmdGnt(gnt4), .winVld(vld4), .winSel(sel4),
        .winBank(o4_bank), .winGroup(o4_group), .winBuf(o4_buf), .winCol(o4_col),
        .winRank(o4_rank), .winLRank(o4_lrank), .winInjTxn(o4_inj), .winRmw(o4_rmw),
        .winAP(o4_ap), .winSize(o4_size)
    );

    ddr4_v2_2_20_mc_cmd_arb_mux_n #(.NUM_CH(4), .CHW(2), .RR_EN(0)) u_fp4 (
        .clk(clk), .rst(rst), .cmdReq(reqfp),
        .cmdBank(bank8[7:0]), .cmdGroup(group8[7:0]), .cmdBuf(buf8[19:0]),
        .cmdCol(col8[39:0]), .cmdRank(rank8[7:0]), .cmdLRank(lrank8[3:0]),
        .cmdInjTxn(inj8[3:0]), .cmdRmw(rmw8[3:0]), .cmdAP(ap8[3:0]), .cmdSize(size8[3:0]),
        .winRdy(rdyfp), .cmdGnt(gntfp), .winVld(vldfp), .winSel(selfp),
        .winBank(ofp_bank), .winGroup(ofp_group), .winBuf(ofp_buf), .winCol(ofp_col),
        .winRank(ofp_rank), .winLRank(ofp_lrank), .winInjTxn(ofp_inj), .winRmw(ofp_rmw),
        .winAP(ofp_ap), .winSize(ofp_size)
    );

    ddr4_v2_2_20_mc_cmd_arb_mux_n #(.NUM_CH(8), .CHW(3), .RR_EN(1)) u_rr8 (
        .clk(clk), .rst(rst), .cmdReq(req8),
        .cmdBank(bank8), .cmdGroup(group8), .cmdBuf(buf8),
        .cmdCol(col8), .cmdRank(rank8), .cmdLRank(lrank8),
        .cmdInjTxn(inj8), .cmdRmw(rmw8), .cmdAP(ap8), .cmdSize(size8),
        .winRdy(rdy8), .cmdGnt(gnt8), .winVld(vld8), .winSel(sel8),
        .winBank(o8_bank), .winGroup(o8_group), .winBuf(o8_buf), .winCol(o8_col),
        .winRank(o8_rank), .winLRank(o8_lrank), .winInjTxn(o8_inj), .winRmw(o8_rmw),
        .winAP(o8_ap), .winSize(o8_size)
    );

    // Output word: {sel, bank, group, buf, col, rank, lrank, inj, rmw, ap, size}
    logic [29:0] out4, outfp, out8;
    assign out4  = {2'b0, sel4, o4_bank, o4_group, o4_buf, o4_col, o4_rank, o4_lrank, o4_inj, o4_rmw, o4_ap, o4_size};
    assign outfp = {2'b0, selfp, ofp_bank, ofp_group, ofp_buf, ofp_col, ofp_rank, ofp_lrank, ofp_inj, ofp_rmw, ofp_ap, ofp_size};
    assign out8  = {1'b0, sel8, o8_bank, o8_group, o8_buf, o8_col, o8_rank, o8_lrank, o8_inj, o8_rmw, o8_ap, o8_size};

    // ---------------- scoreboard ----------------
    logic [29:0] exp4_q[$];
    logic [29:0] expfp_q[$];
    logic [29:0] exp8_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack(input int k, input logic [9:0] col, input logic ap);
        return {4'(k), s_bank[k], s_group[k], s_buf[k], col, s_rank[k], s_lrank[k],
                s_inj[k], s_rmw[k], ap, s_size[k]};
    endfunction

    // Expected command for source k as issued downstream.
    function automatic logic [29:0] exp_cmd(input int k);
        logic [9:0] c;
        c = s_col[k];
        return pack(k, {c[9:3], s_size[k] ? c[2] : 1'b0, 1'b0, s_inj[k]}, s_ap[k] & ~s_rmw[k]);
    endfunction

    // Monitors: compare a presented command at the edge it is consumed.
    always @(negedge clk) begin
        if (!rst && vld4 && rdy4) begin
            if (exp4_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rr4_unexpected: got %h, expected none", out4);
            end else chk("rr4_cmd", {2'b0, out4}, {2'b0, exp4_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && vldfp && rdyfp) begin
            if (expfp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL fp4_unexpected: got %h, expected none", outfp);
            end else chk("fp4_cmd", {2'b0, outfp}, {2'b0, expfp_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && vld8 && rdy8) begin
            if (exp8_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rr8_unexpected: got %h, expected none", out8);
            end else chk("rr8_cmd", {2'b0, out8}, {2'b0, exp8_q.pop_front()});
        end
    end

    // Grant is at most one-hot and always a subset of the requests.
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_legal_rr4", 32'($onehot0(gnt4) && ((gnt4 & ~req4) == 4'b0)), 32'd1);
            chk("gnt_legal_fp4", 32'($onehot0(gntfp) && ((gntfp & ~reqfp) == 4'b0)), 32'd1);
            chk("gnt_legal_rr8", 32'($onehot0(gnt8) && ((gnt8 & ~req8) == 8'b0)), 32'd1);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req4 = 4'b1111; reqfp = '0; req8 = '0;
        rdy4 = 1'b1; rdyfp = 1'b1; rdy8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_bank[k]  = 2'(k);
            s_group[k] = 2'(k + 1);
            s_buf[k]   = 5'(k * 3 + 1);
            s_col[k]   = 10'(341 + k * 37);
            s_rank[k]  = 2'(7 - k);
            s_lrank[k] = k[0];
            s_inj[k]   = (k == 7);
            s_rmw[k]   = (k == 2);
            s_ap[k]    = 1'b1;
            s_size[k]  = ((k % 3) != 0);
        end

        // Reset state, with requests present while rst is high.
        tick(); tick();
        #1;
        chk("rst_vld", 32'(vld4), 32'd0);
        chk("rst_sel", 32'(sel4), 32'd0);
        chk("rst_col", 32'(o4_col), 32'd0);
        chk("rst_gnt", 32'(gnt4), 32'd0);
        chk("rst_vld8", 32'(vld8), 32'd0);
        req4 = '0;
        tick(); rst = 1'b0;
        tick(); tick();
        chk("idle_vld", 32'(vld4), 32'd0);

        // Round-robin with all four requesting: 0,1,2,3,0,1.
        req4 = 4'b1111; rdy4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt4), 32'(4'b0001 << (i % 4)));
            exp4_q.push_back(exp_cmd(i % 4));
            tick();
        end
        req4 = '0;
        tick();
        chk("rr_clear_vld", 32'(vld4), 32'd0);

        // Stall and resume (pointer now at 2).
        req4 = 4'b0100;
        #1;
        chk("stall_setup_gnt", 32'(gnt4), 32'b0100);
        exp4_q.push_back(exp_cmd(2));
        tick();
        req4 = 4'b0001; rdy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_gnt", 32'(gnt4), 32'd0);
            chk("stall_vld", 32'(vld4), 32'd1);
            chk("stall_sel", 32'(sel4), 32'd2);
            chk("stall_cmd", {2'b0, out4}, {2'b0, exp_cmd(2)});
            tick();
        end
        rdy4 = 1'b1;
        #1;
        chk("resume_gnt", 32'(gnt4), 32'b0001);
        exp4_q.push_back(exp_cmd(0));
        tick();
        req4 = '0;
        tick();

        // Column / auto-precharge formatting on source 3.
        s_col[3] = 10'h3FF; s_size[3] = 1'b0; s_inj[3] = 1'b1; s_ap[3] = 1'b1; s_rmw[3] = 1'b1;
        req4 = 4'b1000;
        #1;
        chk("fmt_gnt_a", 32'(gnt4), 32'b1000);
        exp4_q.push_back(pack(3, 10'h3F9, 1'b0));
        tick();
        s_size[3] = 1'b1; s_rmw[3] = 1'b0;
        #1;
        chk("fmt_gnt_b", 32'(gnt4), 32'b1000);
        exp4_q.push_back(pack(3, 10'h3FD, 1'b1));
        tick();
        req4 = '0;
        tick(); tick();

        // Reset in the middle of a stalled transfer (pointer would be at 2).
        req4 = 4'b0010; rdy4 = 1'b1;
        #1;
        chk("mid_gnt", 32'(gnt4), 32'b0010);
        exp4_q.push_back(exp_cmd(1));
        tick();
        req4 = 4'b1010; rdy4 = 1'b0;
        #1;
        chk("mid_stall_gnt", 32'(gnt4), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(vld4), 32'd0);
        chk("mid_rst_gnt", 32'(gnt4), 32'd0);
        exp4_q.delete();
        tick();
        req4 = '0;
        tick();
        rst = 1'b0; rdy4 = 1'b1;
        tick(); tick();
        chk("post_rst_vld", 32'(vld4), 32'd0);
        req4 = 4'b1010;
        #1;
        chk("post_rst_ptr_gnt", 32'(gnt4), 32'b0010);
        exp4_q.push_back(exp_cmd(1));
        tick();
        req4 = '0;
        tick(); tick();

        // Fixed priority: lowest index always wins.
        reqfp = 4'b1010; rdyfp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fp_gnt_1010", 32'(gntfp), 32'b0010);
            expfp_q.push_back(exp_cmd(1));
            tick();
        end
        reqfp = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fp_gnt_1100", 32'(gntfp), 32'b0100);
            expfp_q.push_back(exp_cmd(2));
            tick();
        end
        reqfp = 4'b1111;
        #1;
        chk("fp_gnt_1111", 32'(gntfp), 32'b0001);
        expfp_q.push_back(exp_cmd(0));
        tick();
        reqfp = '0;
        tick(); tick();

        // Eight sources: pointer wraps after index 7.
        req8 = 8'b1000_0000; rdy8 = 1'b1;
        #1;
        chk("wrap_gnt_7", 32'(gnt8), 32'b1000_0000);
        exp8_q.push_back(exp_cmd(7));
        tick();
        req8 = 8'b1000_0001;
        #1;
        chk("wrap_gnt_0", 32'(gnt8), 32'b0000_0001);
        exp8_q.push_back(exp_cmd(0));
        tick();
        #1;
        chk("wrap_gnt_7b", 32'(gnt8), 32'b1000_0000);
        exp8_q.push_back(exp_cmd(7));
        tick();
        req8 = '0;
        tick(); tick(); tick();

        // ---------------- final report ----------------
        chk("rr4_drained", 32'(exp4_q.size()), 32'd0);
        chk("fp4_drained", 32'(expfp_q.size()), 32'd0);
        chk("rr8_drained", 32'(exp8_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr4_v2_2_20_mc_cmd_arb_mux_n.md
Name: ddr4_v2_2_20_mc_cmd_arb_mux_n

Overview:
- Registered N-channel command arbiter and multiplexer for the MC command path.
- Generalises the 4-input combinational casez select to NUM_CH inputs with internal arbitration: fixed-priority or round-robin.
- Adds a one-deep registered output stage with a valid/ready handshake and per-source grant feedback.
- Sits between the per-group command queues and the DRAM command issue stage.

Parameters:
- NUM_CH, 4, number of command sources; legal 2..16.
- CHW, 2, width of the winner index; must satisfy 2**CHW >= NUM_CH.
- COLBITS, 10, column address width; must be >= 4.
- RKBITS, 2, rank field width.
- LR_WIDTH, 1, logical-rank field width.
- DBAW, 5, data buffer address width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmdReq  in  NUM_CH  per-source request, level.
- cmdBank  in  2*NUM_CH  bank per source.
- cmdGroup  in  2*NUM_CH  bank group per source.
- cmdBuf  in  DBAW*NUM_CH  data buffer index per source.
- cmdCol  in  COLBITS*NUM_CH  column per source.
- cmdRank  in  RKBITS*NUM_CH  rank per source.
- cmdLRank  in  LR_WIDTH*NUM_CH  logical rank per source.
- cmdInjTxn, cmdRmw, cmdAP, cmdSize  in  NUM_CH each  per-source flags; cmdSize 1 = BL8, 0 = burst chop.
- winRdy  in  1  downstream accepts the current output.
- cmdGnt  out  NUM_CH  one-hot grant, combinational; the source pops on it.
- winVld  out  1  output register holds a command.
- winSel  out  CHW  index of the registered winner.
- winBank, winGroup (2), winBuf (DBAW), winCol (COLBITS), winRank (RKBITS), winLRank (LR_WIDTH), winInjTxn, winRmw, winAP, winSize (1 each)  out  registered command fields.

Behaviour:
- Reset, asynchronous: winVld=0, winSel=0, all win* fields=0, rrPtr=0. cmdGnt=0 while rst is high.
- Load enable: ld = ~winVld | winRdy. cmdGnt is non-zero only when ld=1 and |cmdReq=1.
- Arbitration, RR_EN=1: search starts at index rrPtr, ascending with wrap modulo NUM_CH; the first requester wins.
- Arbitration, RR_EN=0: lowest index requester wins; rrPtr is unused and stays at 0.
- rrPtr update: on any grant of index k, rrPtr <= (k==NUM_CH-1) ? 0 : k+1. Grants alone advance the pointer.
- Capture: on the clock edge with a grant to k, the output register loads:
  - winBank, winGroup, winBuf, winRank, winLRank, winInjTxn, winRmw, winSize copied from source k.
  - winAP = cmdAP[k] & ~cmdRmw[k].
  - winCol = {col[COLBITS-1:3], cmdSize[k] ? col[2] : 1'b0, 1'b0, cmdInjTxn[k]}, where col is source k's column.
  - winSel = k; winVld = 1.
- Clear: ld=1 with no requests -> winVld <= 0 at the edge. win* fields hold their old values, which are don't-care when winVld=0.
- Stall: winVld=1 and winRdy=0 -> cmdGnt=0; all outputs and rrPtr hold.
- Back-to-back: winVld=1, winRdy=1 and a request present -> the new winner replaces the old one in the same edge. Sustained throughput is 1 command per clock.
- Latency: grant cycle N -> fields visible on win* in cycle N+1.
- Source contract: a source holds cmdReq and its fields stable until granted. A source may drop cmdReq without a grant; the arbiter keeps no memory of it.
- Reset mid-operation: a pending winVld is dropped with no handshake and rrPtr returns to 0.
- Gnt and req: cmdGnt is always a subset of cmdReq and at most one bit is set.

Test Plan:
- Reset and idle: assert rst mid-transfer with winVld=1 -> winVld=0, cmdGnt=0 immediately; after release with cmdReq=0, winVld stays 0.
- Round-robin fairness: NUM_CH=4, RR_EN=1, cmdReq=4'b1111 held, winRdy=1 -> winSel sequence 0,1,2,3,0,1 on consecutive cycles; winVld stays 1.
- Fixed priority: RR_EN=0, cmdReq=4'b1010 -> cmdGnt=4'b0010 every cycle and winSel=1.
- Stall and resume: winVld=1, winSel=2, winRdy=0 for 3 cycles with cmdReq=4'b0001 -> cmdGnt=0 and outputs unchanged; winRdy=1 -> cmdGnt=4'b0001, then winSel=0.
- Column and AP formatting: source 3 with col=10'h3FF, cmdSize=0, cmdInjTxn=1, cmdAP=1, cmdRmw=1 -> winCol=10'h3F9, winAP=0. Same with cmdSize=1, cmdRmw=0 -> winCol=10'h3FD, winAP=1.
- Pointer wrap, NUM_CH=8: after index 7 wins, cmdReq=8'b1000_0001 -> index 0 wins next. Check with an assertion that cmdGnt is one-hot and a subset of cmdReq every cycle.
